// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: branch request and resolution bundle between decode/fetch and branch_ctrl
interface branch_ctrl_if #(parameter int ADDR_W = 32);
    logic              br_valid;
    logic              br_ready;
    logic [3:0]        br_cc;
    logic [ADDR_W-1:0] br_pc;
    logic [ADDR_W-1:0] br_target;
    logic              br_link;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_target;
    logic              lr_we;
    logic [ADDR_W-1:0] lr_data;
    logic              br_done;
    logic              br_taken;
    modport master (
        output br_valid, br_cc, br_pc, br_target, br_link,
        input  br_ready, pc_load, pc_target, lr_we, lr_data, br_done, br_taken
    );
    modport slave (
        input  br_valid, br_cc, br_pc, br_target, br_link,
        output br_ready, pc_load, pc_target, lr_we, lr_data, br_done, br_taken
    );
endinterface

// File: rtl/branch_ctrl.sv
// branch_ctrl: owns NZCV, stalls branches behind in-flight flag writes, resolves and issues PC/LR loads
module branch_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flag_we_i,
    input  logic [3:0]       flag_in_i,
    input  logic             flag_pend_i,
    output logic [3:0]       flags_o,
    output logic [CNT_W-1:0] taken_cnt_o,
    output logic [CNT_W-1:0] nt_cnt_o,
    branch_ctrl_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, WAIT, EVAL, DONE} state_t;
    state_t            state_q, state_d;
    logic [3:0]        flags_q, cc_q;
    logic [ADDR_W-1:0] pc_q, tgt_q, pc_target_q, lr_data_q;
    logic              link_q, pc_load_q, lr_we_q, br_done_q, br_taken_q;
    logic [CNT_W-1:0]  taken_cnt_q, nt_cnt_q;
    logic [7:0]        base;
    logic              taken;
    // Odd codes are the complement of the even code below them, so only 8 base conditions are needed
    always_comb begin
        base  = {1'b1, ~flags_q[2] & (flags_q[3] == flags_q[0]), flags_q[3] == flags_q[0],
                 flags_q[1] & ~flags_q[2], flags_q[0], flags_q[3], flags_q[1], flags_q[2]};
        taken = base[cc_q[3:1]] ^ cc_q[0];
    end
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = bus.br_valid ? (flag_pend_i ? WAIT : EVAL) : IDLE;
            WAIT:    state_d = flag_pend_i ? WAIT : EVAL;
            EVAL:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            flags_q     <= '0;
            cc_q        <= '0;
            pc_q        <= '0;
            tgt_q       <= '0;
            link_q      <= 1'b0;
            pc_load_q   <= 1'b0;
            pc_target_q <= '0;
            lr_we_q     <= 1'b0;
            lr_data_q   <= '0;
            br_done_q   <= 1'b0;
            br_taken_q  <= 1'b0;
            taken_cnt_q <= '0;
            nt_cnt_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_load_q  <= 1'b0;
            lr_we_q    <= 1'b0;
            br_done_q  <= 1'b0;
            br_taken_q <= 1'b0;
            if (flag_we_i) flags_q <= flag_in_i;
            if (state_q == IDLE && bus.br_valid) begin
                cc_q   <= bus.br_cc;
                pc_q   <= bus.br_pc;
                tgt_q  <= bus.br_target;
                link_q <= bus.br_link;
            end
            // Decision uses flags as registered entering EVAL; a same-cycle flag write lands afterwards
            if (state_q == EVAL) begin
                pc_load_q  <= taken;
                lr_we_q    <= taken & link_q;
                br_done_q  <= 1'b1;
                br_taken_q <= taken;
                lr_data_q  <= pc_q + ADDR_W'(4);
                if (taken) begin
                    pc_target_q <= tgt_q;
                    taken_cnt_q <= taken_cnt_q + CNT_W'(1);
                end else begin
                    nt_cnt_q <= nt_cnt_q + CNT_W'(1);
                end
            end
        end
    end
    assign bus.br_ready  = state_q == IDLE;
    assign bus.pc_load   = pc_load_q;
    assign bus.pc_target = pc_target_q;
    assign bus.lr_we     = lr_we_q;
    assign bus.lr_data   = lr_data_q;
    assign bus.br_done   = br_done_q;
    assign bus.br_taken  = br_taken_q;
    assign flags_o       = flags_q;
    assign taken_cnt_o   = taken_cnt_q;
    assign nt_cnt_o      = nt_cnt_q;
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed checks of branch_ctrl handshake, hazard stall, condition table, reset and wrap
module tb_branch_ctrl;
    localparam int AW = 32;
    localparam int CW = 4;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          flag_we = 1'b0;
    logic [3:0]    flag_in = '0;
    logic          flag_pend = 1'b0;
    logic [3:0]    flags;
    logic [CW-1:0] taken_cnt, nt_cnt;
    logic [CW-1:0] exp_tk = '0, exp_nt = '0;
    int            n_chk = 0, n_fail = 0, lat;
    branch_ctrl_if #(.ADDR_W(AW)) bus ();
    branch_ctrl #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .flag_we_i(flag_we), .flag_in_i(flag_in),
        .flag_pend_i(flag_pend), .flags_o(flags), .taken_cnt_o(taken_cnt),
        .nt_cnt_o(nt_cnt), .bus(bus.slave)
    );
    always #5 clk = ~clk;
    function automatic logic ref_taken(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return c;
            4'd3:  return !c;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return c && !z;
            4'd9:  return !c || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic set_flags(input logic [3:0] f);
        flag_we = 1'b1;
        flag_in = f;
        tick();
        flag_we = 1'b0;
    endtask
    // Handshake now, then return in the cycle br_done is seen; lat is cycles after handshake
    task automatic branch(input logic [3:0] cc, input logic [31:0] pc, input logic [31:0] tgt,
                          input logic link, output int l);
        bus.br_valid  = 1'b1;
        bus.br_cc     = cc;
        bus.br_pc     = pc;
        bus.br_target = tgt;
        bus.br_link   = link;
        tick();
        bus.br_valid = 1'b0;
        flag_we      = 1'b0;
        l = 1;
        while (!bus.br_done && l < 20) begin
            tick();
            l++;
        end
    endtask
    initial begin
        bus.br_valid = 1'b0; bus.br_cc = '0; bus.br_pc = '0; bus.br_target = '0; bus.br_link = 1'b0;
        tick();
        tick();
        check("rst_pc_load", bus.pc_load, 0);
        check("rst_done", bus.br_done, 0);
        check("rst_flags", flags, 0);
        reset = 1'b0;
        tick();
        check("rst_ready", bus.br_ready, 1);
        check("rst_target", bus.pc_target, 0);
        check("rst_lr_data", bus.lr_data, 0);
        check("rst_cnt", {taken_cnt, nt_cnt}, 0);
        // Flag write coincident with handshake must be used by this branch
        flag_we = 1'b1; flag_in = 4'b0100;
        branch(4'd0, 32'h100, 32'h200, 1'b1, lat);
        check("t1_lat", lat, 2);
        check("t1_pc_load", bus.pc_load, 1);
        check("t1_target", bus.pc_target, 32'h200);
        check("t1_lr_we", bus.lr_we, 1);
        check("t1_lr_data", bus.lr_data, 32'h104);
        check("t1_taken", bus.br_taken, 1);
        check("t1_tcnt", taken_cnt, 1);
        check("t1_busy", bus.br_ready, 0);
        tick();
        check("t1_pc_load_drop", bus.pc_load, 0);
        check("t1_ready_back", bus.br_ready, 1);
        flag_we = 1'b1; flag_in = 4'b0000;
        branch(4'd0, 32'h300, 32'h400, 1'b1, lat);
        check("t2_done", bus.br_done, 1);
        check("t2_taken", bus.br_taken, 0);
        check("t2_pc_load", bus.pc_load, 0);
        check("t2_lr_we", bus.lr_we, 0);
        check("t2_ncnt", nt_cnt, 1);
        tick();
        // Flag write during EVAL updates the register but not the decision
        bus.br_valid = 1'b1; bus.br_cc = 4'd0; bus.br_link = 1'b0;
        tick();
        bus.br_valid = 1'b0; flag_we = 1'b1; flag_in = 4'b0100;
        tick();
        flag_we = 1'b0;
        check("t3_done", bus.br_done, 1);
        check("t3_taken", bus.br_taken, 0);
        check("t3_flags", flags, 4'b0100);
        check("t3_ncnt", nt_cnt, 2);
        tick();
        // Hazard: pend held 3 cycles, flag write in the last one
        set_flags(4'b0000);
        flag_pend = 1'b1;
        bus.br_valid = 1'b1; bus.br_cc = 4'd11; bus.br_target = 32'h800; bus.br_link = 1'b0;
        tick();
        bus.br_valid = 1'b0;
        check("hz_wait1", bus.br_ready, 0);
        tick();
        flag_we = 1'b1; flag_in = 4'b1000;
        tick();
        flag_we = 1'b0; flag_pend = 1'b0;
        check("hz_wait3", bus.br_done, 0);
        tick();
        check("hz_eval", bus.br_done, 0);
        tick();
        check("hz_done_t5", bus.br_done, 1);
        check("hz_taken", bus.br_taken, 1);
        check("hz_target", bus.pc_target, 32'h800);
        check("hz_flags", flags, 4'b1000);
        tick();
        exp_tk = 2; exp_nt = 2;
        for (int f = 0; f < 16; f++) begin
            set_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                branch(4'(c), 32'h1000, 32'h2000, 1'b0, lat);
                check($sformatf("sweep_cc%0d_f%0h", c, f), bus.br_taken, 32'(ref_taken(4'(c), 4'(f))));
                if (ref_taken(4'(c), 4'(f))) exp_tk++; else exp_nt++;
                tick();
            end
        end
        check("sweep_tcnt", taken_cnt, exp_tk);
        check("sweep_ncnt", nt_cnt, exp_nt);
        // Reset while in WAIT
        set_flags(4'b0100);
        flag_pend = 1'b1;
        bus.br_valid = 1'b1; bus.br_cc = 4'd14;
        tick();
        bus.br_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0; flag_pend = 1'b0;
        check("rw_flags", flags, 0);
        check("rw_ready", bus.br_ready, 1);
        check("rw_cnt", taken_cnt, 0);
        tick();
        check("rw_pc_load", bus.pc_load, 0);
        tick();
        check("rw_pc_load2", bus.pc_load, 0);
        // Reset while in EVAL
        set_flags(4'b0100);
        bus.br_valid = 1'b1; bus.br_cc = 4'd0;
        tick();
        bus.br_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("re_flags", flags, 0);
        check("re_ready", bus.br_ready, 1);
        check("re_pc_load", bus.pc_load, 0);
        tick();
        check("re_pc_load2", bus.pc_load, 0);
        check("re_done", bus.br_done, 0);
        // Counter and link-address wrap
        for (int i = 0; i < 16; i++) begin
            branch(4'd14, (i == 15) ? 32'hFFFF_FFFC : 32'h10, 32'h40, 1'b1, lat);
            if (i == 14) check("wrap_pre", taken_cnt, 15);
            if (i == 15) begin
                check("wrap_tcnt", taken_cnt, 0);
                check("wrap_lr_we", bus.lr_we, 1);
                check("wrap_lr_data", bus.lr_data, 0);
            end
            tick();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
